// File: rtl/bin2bcd_iter_if.sv
// Handshake and result bundle for the iterative binary-to-BCD converter.
// The master drives start/bin_in; the converter (slave) returns status and the result.
interface bin2bcd_iter_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic              start;
  logic [BIN_W-1:0]  bin_in;
  logic              busy;
  logic              done;
  logic [4*DIGITS-1:0] bcd_out;
  logic              ovf;

  modport master (output start, bin_in, input busy, done, bcd_out, ovf);
  modport slave  (input start, bin_in, output busy, done, bcd_out, ovf);
endinterface

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per cycle.
// Define BIN2BCD_ITER_LEADING_BLANK_EN to replace leading zero digits with 4'hF.
module bin2bcd_iter #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input logic           clk,
  input logic           rst,
  bin2bcd_iter_if.slave bus
);
  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_reg;
  logic [BIN_W-1:0] bin_reg;
  logic [SW-1:0]    scratch_reg;
  logic [CW-1:0]    cnt_reg;
  logic             ovf_flag_reg;
  logic [SW-1:0]    bcd_reg;
  logic             ovf_reg;

  logic [SW-1:0]    adj;
  logic [SW-1:0]    shifted;
  logic [SW-1:0]    result;
  logic [SW-1:0]    bcd_next;
  logic             ovf_next;
  logic             accept;

  assign accept = bus.start && (state_reg != S_SHIFT);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_add3
      logic [3:0] dig;
      assign dig = scratch_reg[4*gi +: 4];
      assign adj[4*gi +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
  endgenerate

  // Bit 3 of the adjusted top digit is what the shift pushes out of the scratch.
  assign ovf_next = ovf_flag_reg | adj[SW-1];
  assign shifted  = {adj[SW-2:0], bin_reg[BIN_W-1]};

`ifdef BIN2BCD_ITER_LEADING_BLANK_EN
  logic [DIGITS:1] lead_zero;
  assign lead_zero[DIGITS] = 1'b1;
  assign result[3:0] = shifted[3:0];
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign lead_zero[gi] = lead_zero[gi+1] && (shifted[4*gi +: 4] == 4'd0);
      assign result[4*gi +: 4] = lead_zero[gi] ? 4'hF : shifted[4*gi +: 4];
    end
  endgenerate
`else
  assign result = shifted;
`endif

  assign bcd_next = ovf_next ? {DIGITS{4'd9}} : result;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      bin_reg      <= '0;
      scratch_reg  <= '0;
      cnt_reg      <= '0;
      ovf_flag_reg <= 1'b0;
      bcd_reg      <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (accept) begin
            bin_reg      <= bus.bin_in;
            scratch_reg  <= '0;
            ovf_flag_reg <= 1'b0;
            cnt_reg      <= CW'(BIN_W);
            state_reg    <= S_SHIFT;
          end else begin
            state_reg    <= S_IDLE;
          end
        end
        S_SHIFT: begin
          scratch_reg  <= shifted;
          bin_reg      <= bin_reg << 1;
          ovf_flag_reg <= ovf_next;
          cnt_reg      <= cnt_reg - 1'b1;
          if (cnt_reg == CW'(1)) begin
            state_reg <= S_DONE;
            bcd_reg   <= bcd_next;
            ovf_reg   <= ovf_next;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = (state_reg == S_SHIFT);
  assign bus.done    = (state_reg == S_DONE);
  assign bus.bcd_out = bcd_reg;
  assign bus.ovf     = ovf_reg;
endmodule
